// File: rtl/kitten_spike_unpacker.sv
// Unpacks a packed spike word stream into indexed spikes with end-of-step signalling.
// Define KITTEN_DENSE_FWD_EN to forward every non-padding bit, zeros included.
module kitten_spike_unpacker #(
    parameter int N_POST     = 4096,
    parameter int PACK_WIDTH = 8,
    parameter int IDX_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_step_start,
    input  logic                  i_pack_valid,
    input  logic [PACK_WIDTH-1:0] i_pack_data,
    output logic                  o_pack_ready,
    output logic                  o_spike_valid,
    output logic [IDX_W-1:0]      o_spike_idx,
    output logic                  o_spike,
    input  logic                  i_spike_ready,
    output logic                  o_proj_done,
    output logic [IDX_W-1:0]      o_spike_count
);

    localparam int N_WORDS = (N_POST + PACK_WIDTH - 1) / PACK_WIDTH;
    localparam int WC_W    = $clog2(N_WORDS + 1);
    localparam int KW      = (PACK_WIDTH > 1) ? $clog2(PACK_WIDTH) : 1;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(N_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SCAN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [WC_W-1:0]         word_cnt_q, word_cnt_d;
    logic [31:0]             base_q, base_d;
    logic [IDX_W-1:0]        cur_base_q, cur_base_d;
    logic [PACK_WIDTH-1:0]   pend_q, pend_d;
    logic [PACK_WIDTH-1:0]   data_q, data_d;
    logic [IDX_W-1:0]        count_q, count_d;
    logic                    pack_ready_q, pack_ready_d;
    logic                    spike_valid_q, spike_valid_d;
    logic [IDX_W-1:0]        spike_idx_q, spike_idx_d;
    logic                    spike_q, spike_d;
    logic                    proj_done_q, proj_done_d;
    logic [KW-1:0]           k_cur, k_nxt;

    function automatic logic [KW-1:0] lowest(input logic [PACK_WIDTH-1:0] m);
        lowest = '0;
        for (int i = PACK_WIDTH - 1; i >= 0; i--)
            if (m[i]) lowest = KW'(i);
    endfunction

    // Bits of the word starting at base that address real neurons.
    function automatic logic [PACK_WIDTH-1:0] pad_mask(input logic [31:0] base);
        pad_mask = '0;
        for (int i = 0; i < PACK_WIDTH; i++)
            pad_mask[i] = (base + 32'(i)) < 32'(N_POST);
    endfunction

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        base_d     = base_q;
        cur_base_d = cur_base_q;
        pend_d     = pend_q;
        data_d     = data_q;
        count_d    = count_q;
        k_cur      = lowest(pend_q);
        unique case (state_q)
            S_IDLE: begin
                if (i_step_start) begin
                    state_d    = S_WAIT;
                    word_cnt_d = '0;
                    base_d     = '0;
                    count_d    = '0;
                end
            end
            S_WAIT: begin
                if (i_pack_valid) begin
                    data_d     = i_pack_data & pad_mask(base_q);
`ifdef KITTEN_DENSE_FWD_EN
                    pend_d     = pad_mask(base_q);
`else
                    pend_d     = data_d;
`endif
                    word_cnt_d = word_cnt_q + WC_W'(1);
                    cur_base_d = base_q[IDX_W-1:0];
                    base_d     = base_q + 32'(PACK_WIDTH);
                    if (pend_d != '0)
                        state_d = S_SCAN;
                    else if (word_cnt_d == LAST_WORD)
                        state_d = S_DONE;
                end
            end
            S_SCAN: begin
                if (spike_valid_q && i_spike_ready) begin
                    pend_d = pend_q & ~(PACK_WIDTH'(1) << k_cur);
                    if (spike_q && count_q != '1)
                        count_d = count_q + IDX_W'(1);
                    if (pend_d == '0)
                        state_d = (word_cnt_q == LAST_WORD) ? S_DONE : S_WAIT;
                end
            end
            S_DONE: begin
                if (!i_step_start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are derived from the next state so they line up with it.
    always_comb begin
        k_nxt         = lowest(pend_d);
        pack_ready_d  = (state_d == S_WAIT);
        proj_done_d   = (state_d == S_DONE);
        spike_valid_d = (state_d == S_SCAN);
        spike_idx_d   = spike_idx_q;
        spike_d       = 1'b0;
        if (spike_valid_d) begin
            spike_idx_d = cur_base_d + IDX_W'(k_nxt);
            spike_d     = data_d[k_nxt];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            word_cnt_q    <= '0;
            base_q        <= '0;
            cur_base_q    <= '0;
            pend_q        <= '0;
            data_q        <= '0;
            count_q       <= '0;
            pack_ready_q  <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            spike_q       <= 1'b0;
            proj_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            base_q        <= base_d;
            cur_base_q    <= cur_base_d;
            pend_q        <= pend_d;
            data_q        <= data_d;
            count_q       <= count_d;
            pack_ready_q  <= pack_ready_d;
            spike_valid_q <= spike_valid_d;
            spike_idx_q   <= spike_idx_d;
            spike_q       <= spike_d;
            proj_done_q   <= proj_done_d;
        end
    end

    assign o_pack_ready  = pack_ready_q;
    assign o_spike_valid = spike_valid_q;
    assign o_spike_idx   = spike_idx_q;
    assign o_spike       = spike_q;
    assign o_proj_done   = proj_done_q;
    assign o_spike_count = count_q;

endmodule

// File: tb/tb_kitten_spike_unpacker.sv
// Directed bench for kitten_spike_unpacker with N_POST=12, PACK_WIDTH=8.
// Sparse scenarios by default; dense scenario when KITTEN_DENSE_FWD_EN is defined.
module tb_kitten_spike_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        step_start;
    logic        pack_valid;
    logic [7:0]  pack_data;
    logic        pack_ready;
    logic        spike_valid;
    logic [15:0] spike_idx;
    logic        spike;
    logic        spike_ready;
    logic        proj_done;
    logic [15:0] spike_count;

    int checks = 0;
    int errors = 0;

    kitten_spike_unpacker #(
        .N_POST    (12),
        .PACK_WIDTH(8),
        .IDX_W     (16)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_step_start (step_start),
        .i_pack_valid (pack_valid),
        .i_pack_data  (pack_data),
        .o_pack_ready (pack_ready),
        .o_spike_valid(spike_valid),
        .o_spike_idx  (spike_idx),
        .o_spike      (spike),
        .i_spike_ready(spike_ready),
        .o_proj_done  (proj_done),
        .o_spike_count(spike_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step back through S_IDLE into S_WAIT with the counter cleared.
    task automatic rearm();
        step_start = 1'b0;
        tick();
        step_start = 1'b1;
        tick();
        check("rearm_ready", 32'(pack_ready), 1);
        check("rearm_count", 32'(spike_count), 0);
    endtask

    initial begin
        rst         = 1'b1;
        step_start  = 1'b0;
        pack_valid  = 1'b0;
        pack_data   = 8'h00;
        spike_ready = 1'b1;
        #12;
        check("rst_ready", 32'(pack_ready), 0);
        check("rst_valid", 32'(spike_valid), 0);
        check("rst_idx", 32'(spike_idx), 0);
        check("rst_spike", 32'(spike), 0);
        check("rst_done", 32'(proj_done), 0);
        check("rst_count", 32'(spike_count), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle_ready", 32'(pack_ready), 0);
        step_start = 1'b1;
        tick();
        check("arm_ready", 32'(pack_ready), 1);

`ifdef KITTEN_DENSE_FWD_EN
        begin
            logic [7:0] w;
            w = 8'h05;
            pack_valid = 1'b1;
            pack_data  = w;
            tick();
            pack_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                check("d0_valid", 32'(spike_valid), 1);
                check("d0_idx", 32'(spike_idx), i);
                check("d0_spike", 32'(spike), 32'(w[i]));
                tick();
            end
            check("d0_back_wait", 32'(pack_ready), 1);
            check("d0_count", 32'(spike_count), 2);
            pack_valid = 1'b1;
            pack_data  = 8'hFF;
            tick();
            pack_valid = 1'b0;
            for (int i = 8; i < 12; i++) begin
                check("d1_idx", 32'(spike_idx), i);
                check("d1_spike", 32'(spike), 1);
                tick();
            end
            check("d_done", 32'(proj_done), 1);
            check("d_count", 32'(spike_count), 6);
        end
`else
        // Words 0x81, 0x00: idx 0 and 7 back to back, then done.
        pack_valid = 1'b1;
        pack_data  = 8'h81;
        tick();
        pack_valid = 1'b0;
        check("s_ready_scan", 32'(pack_ready), 0);
        check("s_valid0", 32'(spike_valid), 1);
        check("s_idx0", 32'(spike_idx), 0);
        check("s_spike0", 32'(spike), 1);
        tick();
        check("s_valid7", 32'(spike_valid), 1);
        check("s_idx7", 32'(spike_idx), 7);
        tick();
        check("s_valid_off", 32'(spike_valid), 0);
        check("s_ready_back", 32'(pack_ready), 1);
        check("s_done_early", 32'(proj_done), 0);
        pack_valid = 1'b1;
        pack_data  = 8'h00;
        tick();
        pack_valid = 1'b0;
        check("s_done", 32'(proj_done), 1);
        check("s_count", 32'(spike_count), 2);
        check("s_done_ready", 32'(pack_ready), 0);
        tick();
        check("s_done_hold", 32'(proj_done), 1);
        step_start = 1'b0;
        tick();
        check("s_done_drop", 32'(proj_done), 0);
        step_start = 1'b1;
        tick();
        check("s_rearm_ready", 32'(pack_ready), 1);
        check("s_rearm_count", 32'(spike_count), 0);

        // Backpressure on word 0x06.
        spike_ready = 1'b0;
        pack_valid  = 1'b1;
        pack_data   = 8'h06;
        tick();
        pack_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(spike_valid), 1);
            check("bp_idx1", 32'(spike_idx), 1);
            check("bp_count", 32'(spike_count), 0);
            if (i < 2) tick();
        end
        spike_ready = 1'b1;
        tick();
        check("bp_idx2", 32'(spike_idx), 2);
        check("bp_count1", 32'(spike_count), 1);
        tick();
        check("bp_valid_off", 32'(spike_valid), 0);
        check("bp_count2", 32'(spike_count), 2);
        check("bp_wait", 32'(pack_ready), 1);
        pack_valid = 1'b1;
        pack_data  = 8'h00;
        tick();
        pack_valid = 1'b0;
        check("bp_done", 32'(proj_done), 1);

        // Padding: 0xFF, 0xFF yields idx 0..11 only.
        rearm();
        pack_valid = 1'b1;
        pack_data  = 8'hFF;
        tick();
        pack_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("pad0_valid", 32'(spike_valid), 1);
            check("pad0_idx", 32'(spike_idx), i);
            tick();
        end
        check("pad_wait", 32'(pack_ready), 1);
        pack_valid = 1'b1;
        pack_data  = 8'hFF;
        tick();
        pack_valid = 1'b0;
        for (int i = 8; i < 12; i++) begin
            check("pad1_valid", 32'(spike_valid), 1);
            check("pad1_idx", 32'(spike_idx), i);
            tick();
        end
        check("pad_valid_off", 32'(spike_valid), 0);
        check("pad_done", 32'(proj_done), 1);
        check("pad_count", 32'(spike_count), 12);

        // Reset while idx 3 of word 0x18 is pending.
        rearm();
        spike_ready = 1'b0;
        pack_valid  = 1'b1;
        pack_data   = 8'h18;
        tick();
        pack_valid = 1'b0;
        check("mr_idx3", 32'(spike_idx), 3);
        check("mr_valid", 32'(spike_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_valid_rst", 32'(spike_valid), 0);
        check("mr_idx_rst", 32'(spike_idx), 0);
        check("mr_spike_rst", 32'(spike), 0);
        check("mr_ready_rst", 32'(pack_ready), 0);
        check("mr_done_rst", 32'(proj_done), 0);
        check("mr_count_rst", 32'(spike_count), 0);
        step_start  = 1'b0;
        spike_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("mr_idle_ready", 32'(pack_ready), 0);
        check("mr_idle_valid", 32'(spike_valid), 0);
        step_start = 1'b1;
        tick();
        check("mr_rearm_ready", 32'(pack_ready), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
